sample_dma_writer: RTL and testbench

Captures a stream of WORD_WID-bit samples (e.g. ADC readings) and writes them into main RAM through the DMA word-write interface, two RAM_WORD_WID halves per sample. It is the write-side counterpart of the waveform engine's DMA reader: waveform reads sample buffers out of RAM, and this block fills them. It sits between a free-running sample source and the RAM DMA port. A small FIFO absorbs RAM latency.

---
 rtl/sample_dma_writer.sv | 188 ++++++++++++++++++
 tb/tb_sample_dma_writer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_dma_writer.sv
// sample_dma_writer: captures a strobed stream of WORD_WID-bit samples into a
// small FIFO and writes each one to RAM as two RAM_WORD_WID halves (low half
// first, sign-extended high half second) through a request/acknowledge port.
// Optional feature: define SAMPLE_DMA_WRITER_WRAP_EN for ring-buffer capture
// (the pointer reloads the base address after the last sample, never DONE).
//
// RAM handshake: ram_write is raised with ram_dma_addr/ram_word stable and is
// held until a cycle in which ram_valid is high; that edge completes the
// transfer. ram_valid while ram_write is low is ignored.
module sample_dma_writer #(
   parameter int WORD_WID       = 20,
   parameter int WORD_AMNT_WID  = 11,
   parameter int WORD_AMNT      = 2047,
   parameter int RAM_WID        = 32,
   parameter int RAM_WORD_WID   = 16,
   parameter int RAM_WORD_INCR  = 2,
   parameter int FIFO_DEPTH_WID = 2
) (
   input  logic                     clk,
   input  logic                     rst_L,
   input  logic                     arm,
   input  logic [RAM_WID-1:0]       start_addr,
   input  logic [WORD_WID-1:0]      sample_in,
   input  logic                     sample_strobe,
   output logic [RAM_WID-1:0]       ram_dma_addr,
   output logic [RAM_WORD_WID-1:0]  ram_word,
   output logic                     ram_write,
   input  logic                     ram_valid,
   output logic                     running,
   output logic                     finished,
   output logic                     overflow,
   output logic [WORD_AMNT_WID:0]   sample_count
);

   localparam int DW    = 2 * RAM_WORD_WID;
   localparam int CW    = WORD_AMNT_WID + 1;
   localparam int FW    = FIFO_DEPTH_WID;
   localparam int DEPTH = 1 << FIFO_DEPTH_WID;
   localparam logic [CW-1:0]      LAST_IDX = CW'(WORD_AMNT);
   localparam logic [RAM_WID-1:0] INCR     = RAM_WID'(RAM_WORD_INCR);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      WAIT_SAMPLE = 3'd1,
      WRITE_LO    = 3'd2,
      GAP         = 3'd3,
      WRITE_HI    = 3'd4,
      DONE        = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [RAM_WID-1:0]   ptr_q, ptr_d;
   logic [RAM_WID-1:0]   base_q, base_d;
   logic [DW-1:0]        hold_q, hold_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic [WORD_WID-1:0]  mem_q [DEPTH];
   logic [WORD_WID-1:0]  mem_d [DEPTH];
   logic [FW-1:0]        wr_q, wr_d, rd_q, rd_d;
   logic [FW:0]          fcnt_q, fcnt_d;
   logic                 pop, push, accept, full;

   // State, pointers, holding register and FIFO storage
   always_ff @(posedge clk) begin
      if (!rst_L) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         base_q     <= '0;
         hold_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
         fcnt_q     <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         base_q     <= base_d;
         hold_q     <= hold_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         fcnt_q     <= fcnt_d;
         mem_q      <= mem_d;
      end
   end

   // Next-state logic: capture sequencing plus FIFO push/pop bookkeeping
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      base_d     = base_q;
      hold_d     = hold_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      mem_d      = mem_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      fcnt_d     = fcnt_q;
      pop        = 1'b0;
      accept     = (state_q == WAIT_SAMPLE) || (state_q == WRITE_LO) ||
                   (state_q == GAP) || (state_q == WRITE_HI);
      full       = (fcnt_q == (FW+1)'(DEPTH));

      case (state_q)
         IDLE: begin
            if (arm) begin
               base_d     = start_addr;
               ptr_d      = start_addr;
               count_d    = '0;
               overflow_d = 1'b0;
               state_d    = WAIT_SAMPLE;
            end
         end
         WAIT_SAMPLE: begin
            if (!arm) begin
               state_d = IDLE;
            end else if (fcnt_q != '0) begin
               pop     = 1'b1;
               hold_d  = {{(DW-WORD_WID){mem_q[rd_q][WORD_WID-1]}}, mem_q[rd_q]};
               state_d = WRITE_LO;
            end
         end
         WRITE_LO: begin
            if (ram_valid) begin
               ptr_d   = ptr_q + INCR;
               state_d = GAP;
            end
         end
         GAP: begin
            state_d = WRITE_HI;
         end
         WRITE_HI: begin
            if (ram_valid) begin
               ptr_d   = ptr_q + INCR;
               count_d = count_q + CW'(1);
               if (!arm) begin
                  state_d = IDLE;
               end else if (count_q == LAST_IDX) begin
`ifdef SAMPLE_DMA_WRITER_WRAP_EN
                  ptr_d   = base_q;
                  count_d = '0;
                  state_d = WAIT_SAMPLE;
`else
                  state_d = DONE;
`endif
               end else begin
                  state_d = WAIT_SAMPLE;
               end
            end
         end
         DONE: begin
            if (!arm) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A pop frees a slot in the same cycle, so a full FIFO still takes the push
      push = sample_strobe && accept && (!full || pop);
      if (sample_strobe && accept && full && !pop) overflow_d = 1'b1;
      if (push) begin
         mem_d[wr_q] = sample_in;
         wr_d        = wr_q + FW'(1);
      end
      if (pop) rd_d = rd_q + FW'(1);
      if (push && !pop)      fcnt_d = fcnt_q + (FW+1)'(1);
      else if (pop && !push) fcnt_d = fcnt_q - (FW+1)'(1);

      // IDLE holds the FIFO empty, which flushes it on every entry
      if (state_q == IDLE) begin
         wr_d   = '0;
         rd_d   = '0;
         fcnt_d = '0;
      end
   end

   assign ram_write    = (state_q == WRITE_LO) || (state_q == WRITE_HI);
   assign ram_dma_addr = ptr_q;
   assign ram_word     = (state_q == WRITE_HI) ? hold_q[DW-1:RAM_WORD_WID]
                                               : hold_q[RAM_WORD_WID-1:0];
   assign running      = (state_q != IDLE) && (state_q != DONE);
   assign finished     = (state_q == DONE);
   assign overflow     = overflow_q;
   assign sample_count = count_q;

endmodule

// File: tb/tb_sample_dma_writer.sv
// Directed testbench for sample_dma_writer. Default build uses an 8-sample
// buffer; with SAMPLE_DMA_WRITER_WRAP_EN defined it uses a 2-sample ring.
module tb_sample_dma_writer;

`ifdef SAMPLE_DMA_WRITER_WRAP_EN
   localparam int WA = 1;
`else
   localparam int WA = 7;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_L, arm, sample_strobe, ram_valid;
   logic [31:0] start_addr, ram_dma_addr;
   logic [19:0] sample_in;
   logic [15:0] ram_word;
   logic        ram_write, running, finished, overflow;
   logic [11:0] sample_count;

   always #5 clk = ~clk;

   sample_dma_writer #(.WORD_AMNT(WA)) dut (
      .clk(clk), .rst_L(rst_L), .arm(arm), .start_addr(start_addr),
      .sample_in(sample_in), .sample_strobe(sample_strobe),
      .ram_dma_addr(ram_dma_addr), .ram_word(ram_word), .ram_write(ram_write),
      .ram_valid(ram_valid), .running(running), .finished(finished),
      .overflow(overflow), .sample_count(sample_count)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   // ---------------- RAM responder and write logger ----------------
   bit ack_en    = 1'b1;
   int ack_delay = 0;
   int wait_cnt  = 0;
   logic [47:0] got_q[$];
   logic [47:0] exp_q[$];

   initial begin
      ram_valid = 1'b0;
      forever begin
         @(negedge clk);
         ram_valid = 1'b0;
         if (ram_write && ack_en) begin
            if (wait_cnt == ack_delay) begin
               ram_valid = 1'b1;
               wait_cnt  = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   always @(posedge clk)
      if (rst_L && ram_write && ram_valid) got_q.push_back({ram_dma_addr, ram_word});

   // ---------------- driver tasks ----------------
   task automatic strobe(input logic [19:0] s);
      @(negedge clk);
      sample_in     = s;
      sample_strobe = 1'b1;
      @(negedge clk);
      sample_strobe = 1'b0;
   endtask

   task automatic do_arm(input logic [31:0] a);
      @(negedge clk);
      start_addr = a;
      arm        = 1'b1;
   endtask

   task automatic wait_writes(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (got_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_ram_write(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (ram_write === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_L = 1'b0; arm = 1'b0; sample_strobe = 1'b0;
      sample_in = '0; start_addr = '0;
      repeat (3) @(negedge clk);
      vec_cnt++;
      if ({ram_write, running, finished, overflow} !== 4'b0000) begin
         err_cnt++; $display("FAIL reset_flags got %b exp 0000", {ram_write, running, finished, overflow});
      end
      vec_cnt++;
      if ({ram_dma_addr, ram_word, sample_count} !== 60'h0) begin
         err_cnt++; $display("FAIL reset_data got %h exp 0", {ram_dma_addr, ram_word, sample_count});
      end
      rst_L = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      bit ok;
      ack_en = 1'b1; ack_delay = 0;
      do_arm(32'h1000);
      strobe(20'h80001);
      vec_cnt++;
      if ({running, ram_write} !== 2'b10) begin
         err_cnt++; $display("FAIL basic_after_push got %b exp 10", {running, ram_write});
      end
      @(negedge clk);
      vec_cnt++;
      if ({ram_write, ram_dma_addr, ram_word} !== {1'b1, 32'h1000, 16'h0001}) begin
         err_cnt++; $display("FAIL basic_first_req got %h exp 1_00001000_0001", {ram_write, ram_dma_addr, ram_word});
      end
      exp_q.push_back({32'h1000, 16'h0001});
      exp_q.push_back({32'h1002, 16'hFFF8});
      wait_writes(2, ok);
      vec_cnt++;
      if (!ok) begin err_cnt++; $display("FAIL basic_timeout got %0d writes exp 2", got_q.size()); end
      while (exp_q.size() > 0) begin
         logic [47:0] e, g;
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 48'hx;
         vec_cnt++;
         if (g !== e) begin err_cnt++; $display("FAIL basic_write got %h exp %h", g, e); end
      end
      vec_cnt++;
      if (sample_count !== 12'd1) begin
         err_cnt++; $display("FAIL basic_count got %0d exp 1", sample_count);
      end
      arm = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if (running !== 1'b0) begin err_cnt++; $display("FAIL basic_idle got %b exp 0", running); end
      got_q.delete();
   endtask

`ifndef SAMPLE_DMA_WRITER_WRAP_EN
   logic [19:0] full_smp [8] = '{20'h00001, 20'h7FFFF, 20'h80000, 20'hFFFFF,
                                 20'h12345, 20'hABCDE, 20'h00000, 20'h5A5A5};
   logic [15:0] full_lo  [8] = '{16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF,
                                 16'h2345, 16'hBCDE, 16'h0000, 16'hA5A5};
   logic [15:0] full_hi  [8] = '{16'h0000, 16'h0007, 16'hFFF8, 16'hFFFF,
                                 16'h0001, 16'hFFFA, 16'h0000, 16'h0005};

   task automatic test_full_buffer;
      bit ok;
      ack_en = 1'b1; ack_delay = 3;
      do_arm(32'h1000);
      for (int i = 0; i < 8; i++) begin
         strobe(full_smp[i]);
         repeat (8) @(negedge clk);
         exp_q.push_back({32'h1000 + 32'(4*i),     full_lo[i]});
         exp_q.push_back({32'h1000 + 32'(4*i + 2), full_hi[i]});
      end
      wait_writes(16, ok);
      vec_cnt++;
      if (!ok) begin err_cnt++; $display("FAIL full_timeout got %0d writes exp 16", got_q.size()); end
      vec_cnt++;
      if ({finished, running} !== 2'b10) begin
         err_cnt++; $display("FAIL full_finished got %b exp 10", {finished, running});
      end
      while (exp_q.size() > 0) begin
         logic [47:0] e, g;
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 48'hx;
         vec_cnt++;
         if (g !== e) begin err_cnt++; $display("FAIL full_write got %h exp %h", g, e); end
      end
      strobe(20'h11111);
      repeat (6) @(negedge clk);
      vec_cnt++;
      if ({sample_count, finished, ram_write} !== {12'd8, 1'b1, 1'b0}) begin
         err_cnt++; $display("FAIL full_done_ignores_strobe got %h exp 8_1_0", {sample_count, finished, ram_write});
      end
      vec_cnt++;
      if (got_q.size() !== 0) begin
         err_cnt++; $display("FAIL full_extra_writes got %0d exp 0", got_q.size());
      end
      arm = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if (finished !== 1'b0) begin err_cnt++; $display("FAIL full_finished_drop got %b exp 0", finished); end
      got_q.delete();
   endtask

   task automatic test_overflow;
      bit ok;
      ack_en = 1'b0; ack_delay = 0;
      do_arm(32'h2000);
      for (int i = 1; i <= 5; i++) strobe(20'(i * 20'h00101));
      vec_cnt++;
      if (overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_after_5 got %b exp 0", overflow); end
      strobe(20'h00606);
      vec_cnt++;
      if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_after_6 got %b exp 1", overflow); end
      ack_en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         exp_q.push_back({32'h2000 + 32'(4*(i-1)),     16'(i * 16'h0101)});
         exp_q.push_back({32'h2000 + 32'(4*(i-1) + 2), 16'h0000});
      end
      wait_writes(10, ok);
      vec_cnt++;
      if (!ok) begin err_cnt++; $display("FAIL ovf_timeout got %0d writes exp 10", got_q.size()); end
      repeat (20) @(negedge clk);
      vec_cnt++;
      if (got_q.size() !== 10) begin err_cnt++; $display("FAIL ovf_write_count got %0d exp 10", got_q.size()); end
      while (exp_q.size() > 0) begin
         logic [47:0] e, g;
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 48'hx;
         vec_cnt++;
         if (g !== e) begin err_cnt++; $display("FAIL ovf_write got %h exp %h", g, e); end
      end
      vec_cnt++;
      if ({sample_count, overflow} !== {12'd5, 1'b1}) begin
         err_cnt++; $display("FAIL ovf_final got %h exp 5_1", {sample_count, overflow});
      end
      arm = 1'b0;
      repeat (2) @(negedge clk);
      got_q.delete();
   endtask
`endif

   task automatic test_abort;
      bit ok;
      ack_en = 1'b1; ack_delay = 2;
      do_arm(32'h3000);
      @(negedge clk);
      vec_cnt++;
      if ({overflow, sample_count} !== 13'h0) begin
         err_cnt++; $display("FAIL abort_arm_clears got %h exp 0", {overflow, sample_count});
      end
      strobe(20'h00777);
      wait_ram_write(ok);
      vec_cnt++;
      if (!ok) begin err_cnt++; $display("FAIL abort_req_timeout got %b exp 1", ram_write); end
      sample_in = 20'h00888; sample_strobe = 1'b1; arm = 1'b0;
      @(negedge clk);
      sample_strobe = 1'b0;
      exp_q.push_back({32'h3000, 16'h0777});
      exp_q.push_back({32'h3002, 16'h0000});
      wait_writes(2, ok);
      vec_cnt++;
      if ({ok, running} !== 2'b10) begin
         err_cnt++; $display("FAIL abort_to_idle got %b exp 10", {ok, running});
      end
      repeat (5) @(negedge clk);
      do_arm(32'h4000);
      strobe(20'h00999);
      exp_q.push_back({32'h4000, 16'h0999});
      exp_q.push_back({32'h4002, 16'h0000});
      wait_writes(4, ok);
      vec_cnt++;
      if (!ok) begin err_cnt++; $display("FAIL abort_rearm_timeout got %0d writes exp 4", got_q.size()); end
      repeat (10) @(negedge clk);
      vec_cnt++;
      if (got_q.size() !== 4) begin err_cnt++; $display("FAIL abort_write_count got %0d exp 4", got_q.size()); end
      while (exp_q.size() > 0) begin
         logic [47:0] e, g;
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 48'hx;
         vec_cnt++;
         if (g !== e) begin err_cnt++; $display("FAIL abort_write got %h exp %h", g, e); end
      end
      arm = 1'b0;
      repeat (2) @(negedge clk);
      got_q.delete();
   endtask

   task automatic test_reset_mid_write;
      bit ok;
      ack_en = 1'b0;
      do_arm(32'h5000);
      strobe(20'h00ABC);
      wait_ram_write(ok);
      vec_cnt++;
      if ({ok, running} !== 2'b11) begin err_cnt++; $display("FAIL rstmid_pre got %b exp 11", {ok, running}); end
      rst_L = 1'b0; arm = 1'b0;
      @(negedge clk);
      vec_cnt++;
      if ({ram_write, running, finished, overflow, ram_dma_addr, ram_word, sample_count} !== 64'h0) begin
         err_cnt++; $display("FAIL rstmid_outputs got %h exp 0",
                             {ram_write, running, finished, overflow, ram_dma_addr, ram_word, sample_count});
      end
      rst_L = 1'b1; ack_en = 1'b1;
      repeat (2) @(negedge clk);
      got_q.delete();
   endtask

`ifdef SAMPLE_DMA_WRITER_WRAP_EN
   task automatic test_wrap;
      bit ok;
      ack_en = 1'b1; ack_delay = 0;
      do_arm(32'h6000);
      for (int i = 1; i <= 3; i++) begin
         strobe(20'(i));
         repeat (6) @(negedge clk);
      end
      exp_q.push_back({32'h6000, 16'h0001});
      exp_q.push_back({32'h6002, 16'h0000});
      exp_q.push_back({32'h6004, 16'h0002});
      exp_q.push_back({32'h6006, 16'h0000});
      exp_q.push_back({32'h6000, 16'h0003});
      exp_q.push_back({32'h6002, 16'h0000});
      wait_writes(6, ok);
      vec_cnt++;
      if (!ok) begin err_cnt++; $display("FAIL wrap_timeout got %0d writes exp 6", got_q.size()); end
      while (exp_q.size() > 0) begin
         logic [47:0] e, g;
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 48'hx;
         vec_cnt++;
         if (g !== e) begin err_cnt++; $display("FAIL wrap_write got %h exp %h", g, e); end
      end
      vec_cnt++;
      if ({finished, running, sample_count} !== {1'b0, 1'b1, 12'd1}) begin
         err_cnt++; $display("FAIL wrap_status got %h exp 0_1_001", {finished, running, sample_count});
      end
      arm = 1'b0;
      repeat (2) @(negedge clk);
      got_q.delete();
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
`ifndef SAMPLE_DMA_WRITER_WRAP_EN
      test_full_buffer();
      test_overflow();
`endif
      test_abort();
      test_reset_mid_write();
`ifdef SAMPLE_DMA_WRITER_WRAP_EN
      test_wrap();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
